// File: rtl/game_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_frame_ctrl_if
// Bundles the frame sequencer's handshake with the game-logic datapath and
// the VGA drawer.
//   master : the sequencer (game_frame_ctrl)
//   slave  : datapath / drawer side
// Signals:
//   start          button level              (slave -> master)
//   finish_game    game-over condition       (slave -> master)
//   finish_drawing drawer done with a layer  (slave -> master)
//   pause          hold the frame wait, only with GAME_FRAME_CTRL_PAUSE_EN
//   update         one-cycle update strobe   (master -> slave)
//   plot, draw     VGA write / drawer run enables
//   layer          index of the layer being drawn
//   game_over      high while the game is over
//   overrun        one-cycle frame overrun pulse
//   frame_count    completed frames since start
// Build option: define GAME_FRAME_CTRL_PAUSE_EN to add the pause signal.
// ---------------------------------------------------------------------------
interface game_frame_ctrl_if #(
  parameter int LAYER_W = 1,
  parameter int FC_W    = 16
);
  logic               start;
  logic               finish_game;
  logic               finish_drawing;
`ifdef GAME_FRAME_CTRL_PAUSE_EN
  logic               pause;
`endif
  logic               update;
  logic               plot;
  logic               draw;
  logic [LAYER_W-1:0] layer;
  logic               game_over;
  logic               overrun;
  logic [FC_W-1:0]    frame_count;

`ifdef GAME_FRAME_CTRL_PAUSE_EN
  modport master (
    input  start, finish_game, finish_drawing, pause,
    output update, plot, draw, layer, game_over, overrun, frame_count
  );
  modport slave (
    output start, finish_game, finish_drawing, pause,
    input  update, plot, draw, layer, game_over, overrun, frame_count
  );
`else
  modport master (
    input  start, finish_game, finish_drawing,
    output update, plot, draw, layer, game_over, overrun, frame_count
  );
  modport slave (
    output start, finish_game, finish_drawing,
    input  update, plot, draw, layer, game_over, overrun, frame_count
  );
`endif
endinterface

// File: rtl/game_frame_ctrl.sv
// ---------------------------------------------------------------------------
// game_frame_ctrl
// Fixed-rate frame sequencer: one update strobe, N_LAYERS handshaked draw
// passes, then a wait on an internal frame-period counter so that frames
// start every FRAME_TICKS cycles. Flags frames whose drawing ran past the
// budget, counts completed frames and restarts from game-over.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    game_frame_ctrl_if.master (see interface header for signals)
// Build option: GAME_FRAME_CTRL_PAUSE_EN adds bus.pause, which freezes the
// frame-period counter while waiting for the end of the frame.
// ---------------------------------------------------------------------------
module game_frame_ctrl #(
  parameter int N_LAYERS    = 2,
  parameter int LAYER_W     = 1,
  parameter int FRAME_TICKS = 833333,
  parameter int CNT_W       = 20,
  parameter int FC_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  game_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_WAIT = 3'd1,
    S_UPDATE     = 3'd2,
    S_DRAW       = 3'd3,
    S_LAYER_GAP  = 3'd4,
    S_WAIT_FRAME = 3'd5,
    S_END        = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(N_LAYERS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               late_q;
  logic               overrun_q;
  logic [LAYER_W-1:0] layer_q;
  logic [FC_W-1:0]    fc_q;

  logic cnt_last;
  logic late_now;
  logic pause_w;

  assign cnt_last = (cnt_q == CNT_LAST);
  // Late status as it will be after this edge; used to decide the overrun
  // pulse in the same cycle the last draw pass completes.
  assign late_now = late_q | (cnt_last && (state_q != S_WAIT_FRAME));

`ifdef GAME_FRAME_CTRL_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // NOTE: all state below updates with non-blocking assignments so every
  // register sees the pre-edge values of the others; later assignments in
  // the same block override earlier defaults (counter/late) deliberately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      late_q    <= 1'b0;
      overrun_q <= 1'b0;
      layer_q   <= '0;
      fc_q      <= '0;
    end else begin
      overrun_q <= 1'b0;

      // Frame-period counter saturates at the last tick; pause only freezes
      // it while waiting for the frame boundary.
      if (!cnt_last && !((state_q == S_WAIT_FRAME) && pause_w))
        cnt_q <= cnt_q + CNT_W'(1);

      // Hitting the last tick before reaching WAIT_FRAME means drawing
      // overran the budget for this frame.
      if (cnt_last && (state_q != S_WAIT_FRAME))
        late_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.start) state_q <= S_START_WAIT;
        end
        S_START_WAIT: begin
          if (!bus.start) begin
            state_q <= S_UPDATE;
            cnt_q   <= '0;
          end
        end
        S_UPDATE: begin
          late_q <= 1'b0;
          if (bus.finish_game) begin
            state_q <= S_END;
          end else begin
            state_q <= S_DRAW;
            layer_q <= '0;
          end
        end
        S_DRAW: begin
          if (bus.finish_drawing) begin
            if (layer_q == LAYER_LAST) begin
              state_q   <= S_WAIT_FRAME;
              overrun_q <= late_now;
            end else begin
              state_q <= S_LAYER_GAP;
            end
          end
        end
        S_LAYER_GAP: begin
          // One idle cycle gives the drawer a falling edge on draw.
          layer_q <= layer_q + LAYER_W'(1);
          state_q <= S_DRAW;
        end
        S_WAIT_FRAME: begin
          if (cnt_last && !pause_w) begin
            state_q <= S_UPDATE;
            cnt_q   <= '0;
            fc_q    <= fc_q + FC_W'(1);
          end
        end
        S_END: begin
          if (bus.start) begin
            state_q <= S_START_WAIT;
            fc_q    <= '0;
            layer_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore strobes decoded straight from the state register.
  assign bus.update      = (state_q == S_UPDATE);
  assign bus.plot        = (state_q == S_DRAW);
  assign bus.draw        = (state_q == S_DRAW);
  assign bus.game_over   = (state_q == S_END);
  assign bus.overrun     = overrun_q;
  assign bus.layer       = layer_q;
  assign bus.frame_count = fc_q;

endmodule

// File: doc/game_frame_ctrl.md
Name: game_frame_ctrl

Overview:
Top-level game sequencer, next generation of the single-pass start/update/draw/delay controller. Runs a fixed-rate frame loop: one update pulse, then N_LAYERS sequential draw passes handshaked with the drawer, then a wait on a built-in frame-period counter. The counter replaces the external delay counter and its reset_count/delay_enable pair. Adds frame-overrun detection, a frame counter and restart from game-over; sits between the game-logic datapath and the VGA drawer.

Parameters:
N_LAYERS, 2, number of draw passes per frame (1..2^LAYER_W)
LAYER_W, 1, width of layer index output
FRAME_TICKS, 833333, clock cycles per frame (UPDATE entry to next UPDATE entry), >=2
CNT_W, 20, frame counter width; 2^CNT_W > FRAME_TICKS-1
FC_W, 16, width of frame_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  level start button; press-and-release starts or restarts
finish_game  in  1  game-over condition from datapath, sampled in UPDATE only
finish_drawing  in  1  drawer done for current layer, sampled in DRAW only
update  out  1  one-cycle datapath update strobe
plot  out  1  VGA write enable, high throughout DRAW
draw  out  1  drawer run enable, high throughout DRAW
layer  out  LAYER_W  index of layer being drawn
game_over  out  1  high while in END
overrun  out  1  one-cycle pulse: drawing exceeded frame budget
frame_count  out  FC_W  completed frames since start, wraps

Behaviour:
- States: IDLE, START_WAIT, UPDATE, DRAW, LAYER_GAP, WAIT_FRAME, END. Moore outputs decoded from the state register; layer, frame_count and the counter are registers.
- Reset (async, reset=0): state IDLE; update=plot=draw=game_over=overrun=0; layer=0; frame_count=0; counter=0; sticky late flag=0. Reset mid-frame aborts immediately with no completion of the draw pass.
- IDLE: start=1 -> START_WAIT.
- START_WAIT: stays while start=1; start=0 -> UPDATE.
- UPDATE (1 cycle): update=1; counter<=0 on entry, then increments every cycle, saturating at FRAME_TICKS-1. late flag cleared. finish_game=1 -> END, else -> DRAW with layer=0.
- DRAW: plot=draw=1. finish_drawing=1 with layer<N_LAYERS-1 -> LAYER_GAP. finish_drawing=1 with layer==N_LAYERS-1 -> WAIT_FRAME.
- LAYER_GAP (1 cycle): all strobes 0, so the drawer sees a draw falling edge; layer<=layer+1 at exit -> DRAW.
- If the counter reaches FRAME_TICKS-1 in any state other than WAIT_FRAME, late flag<=1.
- WAIT_FRAME: exit -> UPDATE in the cycle counter==FRAME_TICKS-1; frame_count<=frame_count+1 on that exit.
  - If entered with late=1, overrun=1 for that single WAIT_FRAME cycle, then exit next edge.
  - Result: UPDATE-to-UPDATE period is exactly FRAME_TICKS when drawing fits, otherwise draw time + 1.
- END: game_over=1; all other strobes 0; start=1 -> START_WAIT, frame_count<=0, layer<=0.
- finish_drawing outside DRAW and finish_game outside UPDATE are ignored.
- Unreachable state encodings -> IDLE.

Optional Feature:
GAME_FRAME_CTRL_PAUSE_EN
- With macro: adds input port pause (1 bit, level). While pause=1 in WAIT_FRAME, the counter holds and no exit occurs. On pause=0, counting resumes from the held value. pause is ignored in all other states.
- Without macro: no pause port; WAIT_FRAME behaves as above.

Test Plan:
- FRAME_TICKS=8, N_LAYERS=3, finish_drawing tied 1. Press start 2 cycles, release -> update at release+1. Sequence UPDATE,D0,GAP,D1,GAP,D2,WAIT,WAIT. Next update exactly 8 cycles later; layer 0,1,2; frame_count 1.
- FRAME_TICKS=8, N_LAYERS=2. Each finish_drawing arrives 5 cycles into DRAW -> counter saturates during DRAW. overrun=1 for one cycle in WAIT_FRAME; next update 1 cycle after it; no pulse on a following fast frame.
- finish_game=1 during the 3rd UPDATE -> END: game_over=1, no plot/draw. Press/release start -> frame_count=0, update 1 cycle after release.
- Assert reset during DRAW with layer=1 -> all outputs 0 and layer=0 immediately, before the next clock edge; IDLE ignores finish_drawing.
- Pulse finish_drawing in WAIT_FRAME and finish_game in DRAW -> no state change, no output change.
- PAUSE_EN build, FRAME_TICKS=8. pause=1 for 10 cycles inside WAIT_FRAME -> UPDATE-to-UPDATE period = 18 cycles.
